mips_mc_controller: RTL and testbench
=====================================

// Module: mips_mc_controller
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Decodes the latched instruction
//  (op/funct) and, one state per clock, drives every mux select, write enable and ALU
//  code the datapath consumes. Includes the ALU-control decode and PC-enable logic.
//  Sits beside the datapath and memory in the multicycle top level.
// PARAMETERS
//  ILLEGAL_TRAP  1'b0  0: unknown opcode retires as NOP (back to FETCH); 1: enter HALT
// PORTS
//  clk         in   1  system clock, all state updates on rising edge
//  rst         in   1  reset, synchronous, active-low
//  op          in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag (combinational, current cycle)
//  pcen        out  1  PC register load enable
//  pcsrc       out  2  next-PC select: 00 aluout, 01 aluOUT (registered), 10 jump target
//  alusrca     out  1  0 PC, 1 register A
//  alusrcb     out  2  00 reg B, 01 const 4, 10 immext, 11 immext<<2
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  iord        out  1  memory address: 0 PC, 1 aluOUT
//  irwrite     out  1  instruction register load enable
//  memwrite    out  1  memory write strobe
//  regwrite    out  1  register file write enable
//  regdst      out  1  write address: 0 rt, 1 rd
//  memtoreg    out  1  write data: 0 aluOUT, 1 memory data reg
//  bne_sign    out  1  asserted in BNE execute state
//  halt        out  1  high while in HALT (only reachable when ILLEGAL_TRAP=1)
// BEHAVIOUR
//  - Moore FSM, state register only; outputs decoded from state (+op/funct/zero).
//  - Reset: rst=0 at edge -> state=FETCH next cycle. While rst=0 the outputs pcen, irwrite,
//    memwrite, regwrite, halt and bne_sign are forced 0; all selects show FETCH values
//    (iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, regdst=0, memtoreg=0).
//  - Reset mid-instruction aborts it: no partial write ever issues after rst falls.
//  - States / actions (unlisted outputs 0, alucontrol default 010):
//    FETCH   irwrite=1, alusrcb=01, pcsrc=00, pcen=1 -> DECODE
//    DECODE  alusrcb=11 (branch target into aluOUT) -> by op:
//            lw/sw(100011/101011)->MEMADR; R(000000)->RTYPEEX; beq(000100)->BEQEX;
//            bne(000101)->BNEEX; addi(001000)->ADDIEX; j(000010)->JEX;
//            other -> FETCH (ILLEGAL_TRAP=0) or HALT (=1)
//    MEMADR  alusrca=1, alusrcb=10 -> MEMRD if lw else MEMWR
//    MEMRD   iord=1 -> MEMWB;   MEMWB regwrite=1, memtoreg=1, regdst=0 -> FETCH
//    MEMWR   iord=1, memwrite=1 -> FETCH
//    RTYPEEX alusrca=1, alusrcb=00, alucontrol=funct decode -> RTYPEWB
//    RTYPEWB regwrite=1, regdst=1, memtoreg=0 -> FETCH
//    BEQEX   alusrca=1, alucontrol=110, pcsrc=01, pcen=zero -> FETCH
//    BNEEX   alusrca=1, alucontrol=110, pcsrc=01, bne_sign=1, pcen=~zero -> FETCH
//    ADDIEX  alusrca=1, alusrcb=10 -> ADDIWB; ADDIWB regwrite=1, regdst=0 -> FETCH
//    JEX     pcsrc=10, pcen=1 -> FETCH
//    HALT    halt=1, all enables 0; exits only via reset
//  - pcen = pcwrite | (beq_state & zero) | (bne_state & ~zero).
//  - funct decode (R only): 100000 add->010, 100010 sub->110, 100100 and->000,
//    100101 or->001, 101010 slt->111; unknown funct -> 010, write still occurs.
//  - Latency (cycles incl. FETCH): lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3.
//  - Exactly one of {memwrite, regwrite, irwrite} high in any cycle, or none.
// STRUCTURE
//  - Shared package mips_mc_pkg: opcode and funct constants, state enum (4-bit),
//    alucontrol codes, pcsrc/alusrcb encodings; datapath side imports the same codes.
//  - One sub-module: mips_alu_decoder (alu_op[1:0] + funct -> alucontrol), combinational.
// TESTING
//  - Reset: hold rst=0 3 cycles in any state -> FETCH, pcen=irwrite=regwrite=memwrite=0.
//  - lw (op 100011): state trace FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 only in
//    cycle 5 with memtoreg=1, regdst=0; irwrite=1 only in cycle 1.
//  - R sub (funct 100010): alucontrol=110 in RTYPEEX, regwrite=1 regdst=1 next cycle;
//    repeat for add/and/or/slt -> 010/000/001/111.
//  - beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; zero=0 -> pcen=0. bne with zero=0 ->
//    pcen=1, bne_sign=1; zero=1 -> pcen=0.
//  - j (op 000010): pcen=1, pcsrc=10 in 3rd cycle; sw: memwrite=1 only in 4th cycle.
//  - Illegal op 111111: ILLEGAL_TRAP=0 -> FETCH after DECODE, no writes;
//    ILLEGAL_TRAP=1 -> halt=1 held 10 cycles, rst=0 -> FETCH.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared opcode, funct, ALU and select encodings for the multicycle MIPS
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  // Dispatch out of DECODE; unknown opcodes either retire as a NOP or trap.
  function automatic state_t decode_next(input logic [5:0] op, input logic trap);
    case (op)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE:     decode_next = S_RTYPEEX;
      OP_BEQ:       decode_next = S_BEQEX;
      OP_BNE:       decode_next = S_BNEEX;
      OP_ADDI:      decode_next = S_ADDIEX;
      OP_J:         decode_next = S_JEX;
      default:      decode_next = trap ? S_HALT : S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - controller/datapath control bundle
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       bne_sign;
  logic       halt;

  modport master (
    input  op, funct, zero,
    output pcen, pcsrc, alusrca, alusrcb, alucontrol, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, bne_sign, halt
  );

  modport slave (
    output op, funct, zero,
    input  pcen, pcsrc, alusrca, alusrcb, alucontrol, iord, irwrite,
           memwrite, regwrite, regdst, memtoreg, bne_sign, halt
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - alu_op plus funct to ALU control code
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls back to add; the writeback still happens.
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS main control FSM
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter logic ILLEGAL_TRAP = 1'b0
) (
  input logic clk,
  input logic rst,
  mips_mc_controller_if.master bus
);

  state_t     state;
  logic [1:0] alu_op;
  logic       pcwrite;
  logic       beq_state;
  logic       bne_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   state <= S_DECODE;
        S_DECODE:  state <= decode_next(bus.op, ILLEGAL_TRAP);
        S_MEMADR:  state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state <= S_MEMWB;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_ADDIEX:  state <= S_ADDIWB;
        S_HALT:    state <= S_HALT;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Outputs are pure state decode; reset masks every strobe combinationally so a
  // falling rst kills any in-flight write in the same cycle.
  always_comb begin
    pcwrite      = 1'b0;
    beq_state    = 1'b0;
    bne_state    = 1'b0;
    alu_op       = ALUOP_ADD;
    bus.pcsrc    = PCSRC_ALU;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = SRCB_REGB;
    bus.iord     = 1'b0;
    bus.irwrite  = 1'b0;
    bus.memwrite = 1'b0;
    bus.regwrite = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.bne_sign = 1'b0;
    bus.halt     = 1'b0;
    if (!rst) begin
      bus.alusrcb = SRCB_FOUR;
    end else begin
      case (state)
        S_FETCH: begin
          bus.irwrite = 1'b1;
          bus.alusrcb = SRCB_FOUR;
          bus.pcsrc   = PCSRC_ALU;
          pcwrite     = 1'b1;
        end
        S_DECODE: bus.alusrcb = SRCB_IMMSH;
        S_MEMADR, S_ADDIEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = SRCB_IMM;
        end
        S_MEMRD: bus.iord = 1'b1;
        S_MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        S_MEMWR: begin
          bus.iord     = 1'b1;
          bus.memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          bus.alusrca = 1'b1;
          alu_op      = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        S_BEQEX: begin
          bus.alusrca = 1'b1;
          alu_op      = ALUOP_SUB;
          bus.pcsrc   = PCSRC_ALUOUT;
          beq_state   = 1'b1;
        end
        S_BNEEX: begin
          bus.alusrca  = 1'b1;
          alu_op       = ALUOP_SUB;
          bus.pcsrc    = PCSRC_ALUOUT;
          bus.bne_sign = 1'b1;
          bne_state    = 1'b1;
        end
        S_ADDIWB: bus.regwrite = 1'b1;
        S_JEX: begin
          bus.pcsrc = PCSRC_JUMP;
          pcwrite   = 1'b1;
        end
        S_HALT: bus.halt = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pcen = pcwrite | (beq_state & bus.zero) | (bne_state & ~bus.zero);

  mips_alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed bench for mips_mc_controller
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  mips_mc_controller_if if0 ();
  mips_mc_controller_if if1 ();

  assign if0.op = op;
  assign if0.funct = funct;
  assign if0.zero = zero;
  assign if1.op = op;
  assign if1.funct = funct;
  assign if1.zero = zero;

  mips_mc_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mips_mc_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // {pcen, pcsrc, alusrca, alusrcb, alucontrol, iord, irwrite, memwrite, regwrite, regdst, memtoreg, bne_sign, halt}
  wire [16:0] v0 = {if0.pcen, if0.pcsrc, if0.alusrca, if0.alusrcb, if0.alucontrol, if0.iord,
                    if0.irwrite, if0.memwrite, if0.regwrite, if0.regdst, if0.memtoreg,
                    if0.bne_sign, if0.halt};
  wire [16:0] v1 = {if1.pcen, if1.pcsrc, if1.alusrca, if1.alusrcb, if1.alucontrol, if1.iord,
                    if1.irwrite, if1.memwrite, if1.regwrite, if1.regdst, if1.memtoreg,
                    if1.bne_sign, if1.halt};

  localparam logic [16:0] X_RST     = {1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 8'b0000_0000};
  localparam logic [16:0] X_FETCH   = {1'b1, 2'b00, 1'b0, 2'b01, 3'b010, 8'b0100_0000};
  localparam logic [16:0] X_DECODE  = {1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 8'b0000_0000};
  localparam logic [16:0] X_MEMADR  = {1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 8'b0000_0000};
  localparam logic [16:0] X_MEMRD   = {1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 8'b1000_0000};
  localparam logic [16:0] X_MEMWB   = {1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 8'b0001_0100};
  localparam logic [16:0] X_MEMWR   = {1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 8'b1010_0000};
  localparam logic [16:0] X_RTYPEWB = {1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 8'b0001_1000};
  localparam logic [16:0] X_ADDIWB  = {1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 8'b0001_0000};
  localparam logic [16:0] X_JEX     = {1'b1, 2'b10, 1'b0, 2'b00, 3'b010, 8'b0000_0000};
  localparam logic [16:0] X_HALT    = {1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 8'b0000_0001};

  logic [5:0] f_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [2:0] a_tab [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [16:0] exp, input logic [3:0] st);
    check(tag, 32'(v0), 32'(exp));
    check({tag, "_st"}, 32'(dut0.state), 32'(st));
    check({tag, "_1hot"}, 32'($onehot0({if0.memwrite, if0.regwrite, if0.irwrite})), 32'd1);
    step();
  endtask

  task automatic hold_reset(input string tag);
    rst = 1'b0;
    #0;
    check({tag, "_now"}, 32'(v0), 32'(X_RST));
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_out"}, 32'(v0), 32'(X_RST));
      check({tag, "_st0"}, 32'(dut0.state), 32'(S_FETCH));
      check({tag, "_st1"}, 32'(dut1.state), 32'(S_FETCH));
    end
    rst = 1'b1;
    #0;
  endtask

  initial begin
    #1;
    hold_reset("rst");

    op = OP_LW;
    cyc("lw_c1", X_FETCH, S_FETCH);
    cyc("lw_c2", X_DECODE, S_DECODE);
    cyc("lw_c3", X_MEMADR, S_MEMADR);
    cyc("lw_c4", X_MEMRD, S_MEMRD);
    cyc("lw_c5", X_MEMWB, S_MEMWB);

    op = OP_SW;
    cyc("sw_c1", X_FETCH, S_FETCH);
    cyc("sw_c2", X_DECODE, S_DECODE);
    cyc("sw_c3", X_MEMADR, S_MEMADR);
    cyc("sw_c4", X_MEMWR, S_MEMWR);

    op = OP_RTYPE;
    for (int i = 0; i < 6; i++) begin
      funct = f_tab[i];
      cyc("r_c1", X_FETCH, S_FETCH);
      cyc("r_c2", X_DECODE, S_DECODE);
      cyc("r_ex", {1'b0, 2'b00, 1'b1, 2'b00, a_tab[i], 8'b0}, S_RTYPEEX);
      cyc("r_wb", X_RTYPEWB, S_RTYPEWB);
    end

    op = OP_ADDI;
    cyc("addi_c1", X_FETCH, S_FETCH);
    cyc("addi_c2", X_DECODE, S_DECODE);
    cyc("addi_c3", X_MEMADR, S_ADDIEX);
    cyc("addi_c4", X_ADDIWB, S_ADDIWB);

    op = OP_BEQ;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      cyc("beq_c1", X_FETCH, S_FETCH);
      cyc("beq_c2", X_DECODE, S_DECODE);
      cyc("beq_ex", {z[0], 2'b01, 1'b1, 2'b00, 3'b110, 8'b0}, S_BEQEX);
    end

    op = OP_BNE;
    for (int z = 0; z <= 1; z++) begin
      zero = z[0];
      cyc("bne_c1", X_FETCH, S_FETCH);
      cyc("bne_c2", X_DECODE, S_DECODE);
      cyc("bne_ex", {~z[0], 2'b01, 1'b1, 2'b00, 3'b110, 8'b0000_0010}, S_BNEEX);
    end
    zero = 1'b0;

    op = OP_J;
    cyc("j_c1", X_FETCH, S_FETCH);
    cyc("j_c2", X_DECODE, S_DECODE);
    cyc("j_c3", X_JEX, S_JEX);

    op = 6'b111111;
    cyc("ill_c1", X_FETCH, S_FETCH);
    cyc("ill_c2", X_DECODE, S_DECODE);
    cyc("ill_nop", X_FETCH, S_FETCH);
    for (int i = 0; i < 10; i++) begin
      check("trap_out", 32'(v1), 32'(X_HALT));
      check("trap_st", 32'(dut1.state), 32'(S_HALT));
      step();
    end
    hold_reset("trap_rst");
    check("trap_exit", 32'(v1), 32'(X_FETCH));

    op = OP_SW;
    cyc("abort_c1", X_FETCH, S_FETCH);
    cyc("abort_c2", X_DECODE, S_DECODE);
    cyc("abort_c3", X_MEMADR, S_MEMADR);
    check("abort_pre_st", 32'(dut0.state), 32'(S_MEMWR));
    hold_reset("abort");
    cyc("abort_resume", X_FETCH, S_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
